addition: RTL and testbench



---
 rtl/addition.sv | 72 +++++++
 tb/tb_addition.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/addition.sv
// Signed saturating adder with symmetric clamp to +/-(2^(N-1)-1).
// One-cycle registered result with overflow flags and a sticky saturation flag.
module addition #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sat_clr,
    output logic [N-1:0] s,
    output logic         out_valid,
    output logic         ovf_pos,
    output logic         ovf_neg,
    output logic         sat_sticky
);

    localparam int unsigned RAW_W = N + 1;
    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    // Most-negative code with the LSB set: -(2^(N-1)-1), never 100..0.
    localparam logic [N-1:0] MAX_NEG = {1'b1, {(N-1){1'b0}}} | N'(1);

    logic [RAW_W-1:0] raw_c;
    logic             pos_ovf_c;
    logic             neg_ovf_c;
    logic [N-1:0]     sum_c;
    logic             sticky_next_c;

    // Sign-extended add; overflow decided from operand signs vs raw[N-1].
    always_comb begin
        raw_c     = {a[N-1], a} + {b[N-1], b};
        pos_ovf_c = ~a[N-1] & ~b[N-1] &  raw_c[N-1];
        neg_ovf_c =  a[N-1] &  b[N-1] & ~raw_c[N-1];
        sum_c     = raw_c[N-1:0];
        if (pos_ovf_c) begin
            sum_c = MAX_POS;
        end else if (neg_ovf_c) begin
            sum_c = MAX_NEG;
        end
    end

    // A new saturation takes priority over a same-cycle clear.
    always_comb begin
        sticky_next_c = sat_sticky;
        if (sat_clr) begin
            sticky_next_c = 1'b0;
        end
        if (in_valid && (pos_ovf_c || neg_ovf_c)) begin
            sticky_next_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s          <= '0;
            out_valid  <= 1'b0;
            ovf_pos    <= 1'b0;
            ovf_neg    <= 1'b0;
            sat_sticky <= 1'b0;
        end else begin
            out_valid  <= in_valid;
            sat_sticky <= sticky_next_c;
            if (in_valid) begin
                s       <= sum_c;
                ovf_pos <= pos_ovf_c;
                ovf_neg <= neg_ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_addition.sv
// Randomized self-checking bench for the saturating adder against an
// integer-arithmetic reference model.
module tb_addition;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        sat_clr;
    logic [31:0] s;
    logic        out_valid;
    logic        ovf_pos;
    logic        ovf_neg;
    logic        sat_sticky;

    int tests_run;
    int tests_failed;

    logic [31:0] exp_s;
    logic        exp_ov;
    logic        exp_pos;
    logic        exp_neg;
    logic        exp_sticky;

    addition #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sat_clr   (sat_clr),
        .s         (s),
        .out_valid (out_valid),
        .ovf_pos   (ovf_pos),
        .ovf_neg   (ovf_neg),
        .sat_sticky(sat_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        exp_s = '0; exp_ov = 1'b0; exp_pos = 1'b0; exp_neg = 1'b0; exp_sticky = 1'b0;
    endtask

    // Exact integer sum, then clamp to the symmetric range.
    task automatic model_step(input logic [31:0] ia, input logic [31:0] ib,
                              input logic iv, input logic iclr);
        longint sum;
        sum = longint'($signed(ia)) + longint'($signed(ib));
        exp_ov = iv;
        if (iclr) exp_sticky = 1'b0;
        if (iv) begin
            exp_pos = 1'b0;
            exp_neg = 1'b0;
            if (sum > 64'sd2147483647) begin
                exp_s = 32'h7FFF_FFFF; exp_pos = 1'b1;
            end else if (sum < -64'sd2147483648) begin
                exp_s = 32'h8000_0001; exp_neg = 1'b1;
            end else begin
                exp_s = sum[31:0];
            end
            if (exp_pos || exp_neg) exp_sticky = 1'b1;
        end
    endtask

    task automatic drive(input logic [31:0] ia, input logic [31:0] ib,
                         input logic iv, input logic iclr);
        @(negedge clk);
        a = ia; b = ib; in_valid = iv; sat_clr = iclr;
        model_step(ia, ib, iv, iclr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; sat_clr = 1'b0; a = '0; b = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, ovf_pos, ovf_neg, sat_sticky, s} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset: got %h expected %h",
                     {out_valid, ovf_pos, ovf_neg, sat_sticky, s}, 36'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        va = '{32'h003FFFFF, 32'h002B851E, 32'h0052B020, 32'h00674BC6, 32'hFFD99999,
               32'hFFD99999, 32'h7FFFFFFF, 32'h80000001, 32'h80000000, 32'h80000000};
        vb = '{32'h002147AD, 32'h0005E353, 32'h001B6459, 32'h001B98C7, 32'h003FFFFF,
               32'h803FFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000};
        for (int i = 0; i < 10; i++) begin
            drive(va[i], vb[i], 1'b1, 1'b0);
            tests_run++;
            if ({out_valid, ovf_pos, ovf_neg, sat_sticky, s} !==
                {exp_ov, exp_pos, exp_neg, exp_sticky, exp_s}) begin
                tests_failed++;
                $display("FAIL directed[%0d] %h+%h: got %h expected %h", i, va[i], vb[i],
                         {out_valid, ovf_pos, ovf_neg, sat_sticky, s},
                         {exp_ov, exp_pos, exp_neg, exp_sticky, exp_s});
            end
        end
        // Spot-check the model on the documented vectors.
        tests_run++;
        if (exp_s !== 32'h8000_0001 || s !== 32'h8000_0001) begin
            tests_failed++;
            $display("FAIL wrap_sat: got %h expected %h", s, 32'h8000_0001);
        end
    endtask

    task automatic test_sticky_clear();
        drive(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1);
        tests_run++;
        if (sat_sticky !== 1'b0 || s !== 32'h3) begin
            tests_failed++;
            $display("FAIL sat_clr: got sticky=%b s=%h expected sticky=0 s=3", sat_sticky, s);
        end
        drive(32'h7FFF_0000, 32'h7FFF_0000, 1'b1, 1'b1);
        tests_run++;
        if ({sat_sticky, ovf_pos} !== 2'b11) begin
            tests_failed++;
            $display("FAIL set_wins: got sticky=%b ovf_pos=%b expected 1 1", sat_sticky, ovf_pos);
        end
        drive(32'h0, 32'h0, 1'b0, 1'b1);
        tests_run++;
        if ({out_valid, sat_sticky, ovf_pos, s} !== {1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF}) begin
            tests_failed++;
            $display("FAIL clr_idle: got %h expected %h", {out_valid, sat_sticky, ovf_pos, s},
                     {1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF});
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
            1: return 32'h8000_0000 + 32'($urandom_range(0, 3));
            2: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            drive(rand_operand(), rand_operand(), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0));
            tests_run++;
            if ({out_valid, ovf_pos, ovf_neg, sat_sticky, s} !==
                {exp_ov, exp_pos, exp_neg, exp_sticky, exp_s}) begin
                tests_failed++;
                $display("FAIL random[%0d] %h+%h: got %h expected %h", i, a, b,
                         {out_valid, ovf_pos, ovf_neg, sat_sticky, s},
                         {exp_ov, exp_pos, exp_neg, exp_sticky, exp_s});
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        drive(32'h7FFF_FFFF, 32'h0000_0010, 1'b1, 1'b0);
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({out_valid, ovf_pos, ovf_neg, sat_sticky, s} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_async: got %h expected %h",
                     {out_valid, ovf_pos, ovf_neg, sat_sticky, s}, 36'h0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'($urandom), 32'($urandom), 1'b0, 1'b0);
            tests_run++;
            if ({out_valid, s} !== 33'h0) begin
                tests_failed++;
                $display("FAIL hold_after_reset[%0d]: got %h expected %h", i, {out_valid, s}, 33'h0);
            end
        end
        drive(32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0);
        tests_run++;
        if ({out_valid, s} !== {1'b1, 32'h0000_0003}) begin
            tests_failed++;
            $display("FAIL first_after_reset: got %h expected %h", {out_valid, s},
                     {1'b1, 32'h0000_0003});
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_sticky_clear();
        test_back_to_back();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
